// File: rtl/sseg_pkg.sv
// Shared types and constants for the serial seven-segment driver:
// FSM state encoding, the blank byte and the active-high hex glyph table.
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } sseg_state_e;

  localparam logic [7:0] BLANK_BYTE = 8'hFF;

  // Glyphs as {g,f,e,d,c,b,a}, 1 = lit; entry 15 is leftmost.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sseg_hex_enc.sv
// Combinational nibble to seven-segment glyph, active-high {g,f,e,d,c,b,a}.
module sseg_hex_enc
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/sseg_serial_drv.sv
// Frame-based serial driver for chained seven-segment shift registers.
// Define SSEG_BLINK_EN to blank digits with les[i] & flash at frame load.
module sseg_serial_drv
  import sseg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [8*DIGITS-1:0]   disp_num,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     les,
  input  logic                  flash,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_pen,
  output logic                  seg_clrn,
  output logic                  busy,
  output logic                  done
);

  localparam int FRAME_W = 8 * DIGITS;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIGITS-1:0][6:0] glyph;
  logic [FRAME_W-1:0]     frame_build;

  // Digit DIGITS-1 lands in the top byte so it leaves the shifter first.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [7:0] lit;

    sseg_hex_enc u_enc (
      .nibble_i (disp_num[4*g +: 4]),
      .glyph_o  (glyph[g])
    );

    assign lit = mode ? disp_num[8*g +: 8] : {point[g], glyph[g]};

`ifdef SSEG_BLINK_EN
    assign frame_build[8*g +: 8] = (les[g] & flash) ? BLANK_BYTE : ~lit;
`else
    assign frame_build[8*g +: 8] = ~lit;
`endif
  end

`ifndef SSEG_BLINK_EN
  logic unused_blink;
  assign unused_blink = ^{les, flash};
`endif

  sseg_state_e        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               pending_q, pending_d;
  logic               seg_clk_q, seg_clk_d;
  logic               sout_q, sout_d;
  logic               pen_q, pen_d;
  logic               clrn_q;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    div_d     = div_q;
    seg_clk_d = seg_clk_q;
    sout_d    = sout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pen_d     = pen_q | done_q;
    pending_d = pending_q | (start & busy_q);

    unique case (state_q)
      ST_IDLE: begin
        pending_d = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        frame_d   = frame_build;
        sout_d    = frame_build[FRAME_W-1];
        bit_d     = '0;
        div_d     = '0;
        seg_clk_d = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!seg_clk_q) begin
            seg_clk_d = 1'b1;
          end else begin
            seg_clk_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = ST_LATCH;
              done_d  = 1'b1;
            end else begin
              // Data only moves on entry to the low phase.
              bit_d   = bit_q + 1'b1;
              frame_d = frame_q << 1;
              sout_d  = frame_q[FRAME_W-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (pending_q | start) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      div_q     <= '0;
      pending_q <= 1'b0;
      seg_clk_q <= 1'b0;
      sout_q    <= 1'b0;
      pen_q     <= 1'b0;
      clrn_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      pending_q <= pending_d;
      seg_clk_q <= seg_clk_d;
      sout_q    <= sout_d;
      pen_q     <= pen_d;
      clrn_q    <= 1'b1;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // NOTE: the frame shifter is always written in LOAD before it is read,
  // so it carries no reset and stays a plain register bank.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign seg_clk  = seg_clk_q;
  assign seg_sout = sout_q;
  assign seg_pen  = pen_q;
  assign seg_clrn = clrn_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sseg_serial_drv.sv
// Self-checking bench: two driver instances (8 digits / div 2, 4 digits / div 1)
// compared every cycle against a frame-position model, plus directed literals.
module tb_sseg_serial_drv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  localparam int DG [2] = '{8, 4};
  localparam int CD [2] = '{2, 1};
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
`ifdef SSEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
  localparam logic [7:0] BLINK_LAST = 8'hFF;
`else
  localparam bit BLINK_ON = 1'b0;
  localparam logic [7:0] BLINK_LAST = 8'hF8;
`endif

  logic [1:0]  st, rs, md, fl;
  logic [63:0] num [2];
  logic [7:0]  pt  [2];
  logic [7:0]  le  [2];
  logic [1:0]  sclk, ssout, spen, sclrn, sbusy, sdone;

  sseg_serial_drv #(.DIGITS(8), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rs[0]), .start(st[0]), .mode(md[0]),
    .disp_num(num[0]), .point(pt[0]), .les(le[0]), .flash(fl[0]),
    .seg_clk(sclk[0]), .seg_sout(ssout[0]), .seg_pen(spen[0]),
    .seg_clrn(sclrn[0]), .busy(sbusy[0]), .done(sdone[0])
  );

  sseg_serial_drv #(.DIGITS(4), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rs[1]), .start(st[1]), .mode(md[1]),
    .disp_num(num[1][31:0]), .point(pt[1][3:0]), .les(le[1][3:0]), .flash(fl[1]),
    .seg_clk(sclk[1]), .seg_sout(ssout[1]), .seg_pen(spen[1]),
    .seg_clrn(sclrn[1]), .busy(sbusy[1]), .done(sdone[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Expected frame straight from the byte-layout rules.
  function automatic logic [63:0] build(int d, bit m, logic [63:0] n, logic [7:0] p,
                                        logic [7:0] l, bit f);
    logic [63:0] fr = '0;
    logic [7:0]  b;
    for (int i = 0; i < d; i++) begin
      if (m) b = ~n[8*i +: 8];
      else   b = ~{p[i], GLYPH[n[4*i +: 4]]};
      if (BLINK_ON && l[i] && f) b = 8'hFF;
      fr[8*i +: 8] = b;
    end
    return fr;
  endfunction

  // Model: mk is the position within a frame (-1 idle, 0 load, 1..N shift, N+1 latch).
  int          mk     [2] = '{-1, -1};
  bit          mpend  [2];
  bit          mpen   [2];
  bit          mclrn  [2];
  bit          msout  [2];
  bit          mvalid [2];
  logic [63:0] mframe [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int n, k, nk;
      bit pn;
      n = 16 * DG[u] * CD[u];
      k = mk[u];
      if (rs[u]) begin
        mk[u] = -1; mpend[u] = 0; mpen[u] = 0; mclrn[u] = 0; msout[u] = 0; mvalid[u] = 1;
      end else begin
        mclrn[u] = 1;
        if (k == n + 1) mpen[u] = 1;
        pn = mpend[u] | (st[u] && k >= 0);
        if (k == -1)      nk = st[u] ? 0 : -1;
        else if (k == 0) begin
          mframe[u] = build(DG[u], md[u], num[u], pt[u], le[u], fl[u]);
          nk = 1;
        end
        else if (k <= n)  nk = k + 1;
        else              nk = pn ? 0 : -1;
        if (nk == 0) pn = 0;
        mpend[u] = pn;
        mk[u] = nk;
        if (nk >= 1 && nk <= n) msout[u] = mframe[u][8*DG[u] - 1 - (nk - 1) / (2 * CD[u])];
      end
    end
  end

  function automatic logic [5:0] exp_outs(int u);
    int n, k;
    bit c;
    n = 16 * DG[u] * CD[u];
    k = mk[u];
    c = (k >= 1 && k <= n) && (((k - 1) % (2 * CD[u])) >= CD[u]);
    return {c, msout[u], mpen[u], mclrn[u], k >= 0, k == n + 1};
  endfunction

  function automatic logic [5:0] outs(int u);
    return {sclk[u], ssout[u], spen[u], sclrn[u], sbusy[u], sdone[u]};
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++)
      if (mvalid[u]) check($sformatf("outs%0d", u), outs(u), exp_outs(u));
  end

  // Independent capture of what a shift register on the pins would clock in.
  logic [63:0] cap  [2] = '{64'd0, 64'd0};
  int          capn [2] = '{0, 0};
  logic [1:0]  pclk = '0;
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (sclk[u] && !pclk[u]) begin
        cap[u] = {cap[u][62:0], ssout[u]};
        capn[u]++;
      end
      pclk[u] = sclk[u];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int u, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (sdone[u]) begin at = cyc; break; end
      tick(1);
    end
  endtask

  task automatic run_frame(input int u, output int lat);
    int t0, at;
    st[u] = 1'b1;
    t0 = cyc;
    tick(1);
    st[u] = 1'b0;
    wait_done(u, 600, at);
    lat = (at < 0) ? -1 : at - t0;
  endtask

  initial begin
    int lat, n0, d1, d2, cnt;
    st = '0; md = '0; fl = '0; rs = 2'b11;
    for (int u = 0; u < 2; u++) begin num[u] = '0; pt[u] = '0; le[u] = '0; end
    tick(2);
    check("reset_outs0", outs(0), 6'b000000);
    check("reset_outs1", outs(1), 6'b000000);
    rs = 2'b00;
    tick(1);
    check("clrn_after_reset", sclrn[0], 1'b1);
    tick(2);

    // Text frame, literal bytes and latency.
    num[0] = 64'h0000_0000_0123_4567;
    n0 = capn[0];
    run_frame(0, lat);
    check("latency_text", lat, 258);
    check("pen_at_first_done", spen[0], 1'b0);
    check("bits_text", capn[0] - n0, 64);
    check("first_byte", cap[0][63:56], 8'hC0);
    check("second_byte", cap[0][55:48], 8'hF9);
    check("last_byte", cap[0][7:0], 8'hF8);
    tick(1);
    check("pen_after_done", spen[0], 1'b1);
    tick(3);

    // Graphic frame.
    md[0] = 1'b1;
    num[0] = 64'h8000_0000_0000_0000;
    run_frame(0, lat);
    check("latency_graphic", lat, 258);
    check("graphic_frame", cap[0], 64'h7FFF_FFFF_FFFF_FFFF);
    md[0] = 1'b0;
    tick(3);

    // Held start mid-frame: exactly one extra frame with the new data.
    num[0] = 64'h0000_0000_0123_4567;
    st[0] = 1'b1;
    n0 = cyc;
    tick(1);
    st[0] = 1'b0;
    tick(49);
    num[0] = 64'h0000_0000_89AB_CDEF;
    st[0] = 1'b1;
    tick(3);
    st[0] = 1'b0;
    wait_done(0, 600, d1);
    check("pend_first_latency", d1 - n0, 258);
    tick(1);
    check("pend_load_busy", sbusy[0], 1'b1);
    wait_done(0, 600, d2);
    check("pend_second_gap", d2 - d1, 258);
    check("pend_first_byte", cap[0][63:56], 8'h80);
    check("pend_last_byte", cap[0][7:0], 8'h8E);
    cnt = 0;
    repeat (300) begin tick(1); cnt += int'(sdone[0]); end
    check("extra_frames", cnt, 0);

    // Blink on digit 0.
    num[0] = 64'h0000_0000_0123_4567;
    le[0] = 8'h01;
    fl[0] = 1'b1;
    run_frame(0, lat);
    check("blink_last_byte", cap[0][7:0], BLINK_LAST);
    check("blink_first_byte", cap[0][63:56], 8'hC0);
    le[0] = '0;
    fl[0] = 1'b0;
    tick(3);

    // Reset 40 cycles into a frame.
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(39);
    rs[0] = 1'b1;
    tick(1);
    rs[0] = 1'b0;
    check("midframe_reset_outs", outs(0), 6'b000000);
    cnt = 0;
    repeat (300) begin tick(1); cnt += int'(sdone[0]); end
    check("no_done_after_abort", cnt, 0);
    run_frame(0, lat);
    check("latency_after_abort", lat, 258);

    // Fast divider, 4 digits.
    num[1] = 64'h0000_0000_0123_4567;
    n0 = capn[1];
    run_frame(1, lat);
    check("latency_div1", lat, 66);
    check("bits_div1", capn[1] - n0, 32);
    check("frame_div1", cap[1][31:0], 32'h9992_82F8);
    tick(3);

    // Randomized traffic on both instances, checked cycle by cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int u = 0; u < 2; u++) begin
        st[u]  = ($urandom_range(0, 19) == 0);
        md[u]  = 1'($urandom);
        num[u] = {$urandom, $urandom};
        pt[u]  = 8'($urandom);
        le[u]  = 8'($urandom);
        fl[u]  = 1'($urandom);
        rs[u]  = ($urandom_range(0, 499) == 0);
      end
      tick(1);
    end
    st = '0; rs = '0;
    tick(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
